matvec3_feeder: RTL and testbench

Serializes one complete 3x3 matrix-vector problem, presented as a single parallel frame, into the 14-bit word stream consumed by `matvec3_part1`. The stream carries nine matrix words in row-major order, then three vector words. Sits between a problem source (DMA, register file, or test harness) and the matvec input port, and is the transmitting end of that valid/ready input interface. Sustains back-to-back frames with no idle cycle between them.

---
 rtl/matvec_pkg.sv | 14 +
 rtl/matvec3_feeder.sv | 92 +++++++++
 tb/tb_matvec3_feeder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_pkg.sv
// matvec_pkg: shared sizing, word type and feeder state encoding for the
// 3x3 matrix-vector datapath and its input feeder.
package matvec_pkg;

  localparam int K       = 3;
  localparam int W       = 14;
  localparam int N_WORDS = K*K + K;
  localparam int IDX_W   = $clog2(N_WORDS);

  typedef logic signed [W-1:0] word_t;

  typedef enum logic {IDLE, SEND} feeder_state_t;

endpackage

// File: rtl/matvec3_feeder.sv
// matvec3_feeder: captures one whole matrix-vector problem as a parallel
// frame and streams it out as K*K matrix words (row-major) followed by K
// vector words over a valid/ready word interface. A new frame can be taken
// in the same cycle the last word of the current frame leaves, so frames
// stream back to back without a bubble.
// Optional build macro MATVEC3_FEEDER_LAST_EN adds output_last, which marks
// the final word of each frame.
module matvec3_feeder #(
  parameter int K = matvec_pkg::K,
  parameter int W = matvec_pkg::W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  input  logic [(K*K+K)*W-1:0] frame_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [W-1:0]         output_data
`ifdef MATVEC3_FEEDER_LAST_EN
  ,
  output logic                 output_last
`endif
);

  import matvec_pkg::*;

  localparam int N  = K*K + K;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  feeder_state_t r_state;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_buf [N];

  logic w_last;
  logic w_word_xfer;
  logic w_frame_ready;
  logic w_frame_xfer;

  // Handshake decode; frame_ready looks at output_ready so the next frame can
  // be taken in the same cycle the final word is accepted, and is held low
  // while reset is asserted.
  always_comb begin
    w_last        = (r_idx == LAST_IDX);
    w_word_xfer   = (r_state == SEND) && output_ready;
    w_frame_ready = reset &&
                    ((r_state == IDLE) ||
                     ((r_state == SEND) && w_last && output_ready));
    w_frame_xfer  = frame_valid && w_frame_ready;
  end

  // Feeder FSM: frame capture, word index advance and return to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      for (int e = 0; e < N; e++) begin
        r_buf[e] <= '0;
      end
    end else if (w_frame_xfer) begin
      for (int e = 0; e < N; e++) begin
        r_buf[e] <= frame_data[e*W +: W];
      end
      r_idx   <= '0;
      r_state <= SEND;
    end else if (w_word_xfer) begin
      if (w_last) begin
        r_idx   <= '0;
        r_state <= IDLE;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Word mux; the stream is forced to zero when idle so nothing undefined
  // ever reaches the consumer.
  always_comb begin
    output_valid = (r_state == SEND);
    output_data  = output_valid ? r_buf[r_idx] : '0;
    frame_ready  = w_frame_ready;
  end

`ifdef MATVEC3_FEEDER_LAST_EN
  // Last-word marker for consumers that do not count words themselves.
  always_comb begin
    output_last = (r_state == SEND) && w_last;
  end
`endif

endmodule

// File: tb/tb_matvec3_feeder.sv
// tb_matvec3_feeder: directed and random checks of the frame-to-word feeder.
// Inputs are driven 1 time unit after each rising edge and outputs sampled
// 2 units after it. Build with MATVEC3_FEEDER_LAST_EN to also check
// output_last.
module tb_matvec3_feeder;

  localparam int N  = 12;
  localparam int W  = 14;
  localparam int FW = N*W;
  localparam int NUM_RANDOM_FRAMES = 1000;
  localparam int RANDOM_CYCLE_LIMIT = 60000;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_valid;
  logic          frame_ready;
  logic [FW-1:0] frame_data;
  logic          output_valid;
  logic          output_ready;
  logic [W-1:0]  output_data;
`ifdef MATVEC3_FEEDER_LAST_EN
  logic          output_last;
`endif

  int checks   = 0;
  int failures = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  matvec3_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .frame_data   (frame_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
`ifdef MATVEC3_FEEDER_LAST_EN
    ,
    .output_last  (output_last)
`endif
  );

  // Builds a frame whose word e is start + e*step, modulo 2^14.
  function automatic logic [FW-1:0] mkSeq(input logic [W-1:0] start, input logic [W-1:0] stepVal);
    logic [FW-1:0] f;
    logic [W-1:0]  v;
    v = start;
    for (int e = 0; e < N; e++) begin
      f[e*W +: W] = v;
      v = v + stepVal;
    end
    return f;
  endfunction

  // Moves to the drive point of the next cycle.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reset holds every output low, frame_ready rises once reset releases.
  task automatic test_reset();
    reset = 1'b0;
    frame_valid = 1'b0;
    output_ready = 1'b0;
    frame_data = '0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", output_valid); end
    checks++;
    if (output_data !== 14'h0) begin failures++; $display("[TB] FAIL reset_data: got %h expected 0000", output_data); end
    checks++;
    if (frame_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_ready: got %b expected 0", frame_ready); end
`ifdef MATVEC3_FEEDER_LAST_EN
    checks++;
    if (output_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_last: got %b expected 0", output_last); end
`endif
    reset = 1'b1;
    #1;
    checks++;
    if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_frame_ready: got %b expected 1", frame_ready); end
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_valid: got %b expected 0", output_valid); end
    nextCycle();
  endtask

  // One frame of words 1..12 with output_ready held high.
  task automatic test_single_frame();
    frame_data = mkSeq(14'd1, 14'd1);
    frame_valid = 1'b1;
    output_ready = 1'b1;
    #1;
    checks++;
    if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_accept: got %b expected 1", frame_ready); end
    nextCycle();
    frame_valid = 1'b0;
    frame_data = 'x;
    for (int i = 0; i < N; i++) begin
      #1;
      checks++;
      if (output_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, output_valid); end
      checks++;
      if (output_data !== 14'(i + 1)) begin failures++; $display("[TB] FAIL single_data[%0d]: got %h expected %h", i, output_data, 14'(i + 1)); end
`ifdef MATVEC3_FEEDER_LAST_EN
      checks++;
      if (output_last !== (i == N - 1)) begin failures++; $display("[TB] FAIL single_last[%0d]: got %b expected %b", i, output_last, (i == N - 1)); end
`endif
      nextCycle();
    end
    #1;
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_end_valid: got %b expected 0", output_valid); end
    checks++;
    if (output_data !== 14'h0) begin failures++; $display("[TB] FAIL single_end_data: got %h expected 0000", output_data); end
    checks++;
    if (frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_end_frame_ready: got %b expected 1", frame_ready); end
    nextCycle();
  endtask

  // Frames A (1..12) and B (-1..-12) back to back, B taken with A's last word.
  task automatic test_back_to_back();
    logic [W-1:0] expB;
    frame_data = mkSeq(14'h0001, 14'h0001);
    frame_valid = 1'b1;
    output_ready = 1'b1;
    nextCycle();
    frame_valid = 1'b0;
    frame_data = 'x;
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) begin
        frame_valid = 1'b1;
        frame_data = mkSeq(14'h3FFF, 14'h3FFF);
      end
      #1;
      checks++;
      if (output_data !== 14'(i + 1) || output_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_a_data[%0d]: got %h/%b expected %h/1", i, output_data, output_valid, 14'(i + 1)); end
      checks++;
      if (frame_ready !== (i == N - 1)) begin failures++; $display("[TB] FAIL b2b_frame_ready[%0d]: got %b expected %b", i, frame_ready, (i == N - 1)); end
      nextCycle();
      frame_valid = 1'b0;
      frame_data = 'x;
    end
    for (int i = 0; i < N; i++) begin
      expB = 14'h3FFF - 14'(i);
      #1;
      checks++;
      if (output_data !== expB || output_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_b_data[%0d]: got %h/%b expected %h/1", i, output_data, output_valid, expB); end
      nextCycle();
    end
    #1;
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end_valid: got %b expected 0", output_valid); end
    nextCycle();
  endtask

  // X on frame_data while mid-frame must be refused and never reach the stream.
  task automatic test_frame_x_ignored();
    int k;
    int cyc;
    logic expReady;
    frame_data = mkSeq(14'd1, 14'd1);
    frame_valid = 1'b1;
    output_ready = 1'b1;
    nextCycle();
    k = 0;
    cyc = 0;
    while (k < N && cyc < 40) begin
      output_ready = (cyc % 3) != 1;
      frame_valid = (k < N - 1);
      frame_data = 'x;
      #1;
      expReady = (k == N - 1) ? output_ready : 1'b0;
      checks++;
      if (frame_ready !== expReady) begin failures++; $display("[TB] FAIL xin_frame_ready[%0d]: got %b expected %b", k, frame_ready, expReady); end
      checks++;
      if (output_data !== 14'(k + 1) || output_valid !== 1'b1) begin failures++; $display("[TB] FAIL xin_data[%0d]: got %h/%b expected %h/1", k, output_data, output_valid, 14'(k + 1)); end
      if (output_ready) k++;
      cyc++;
      nextCycle();
    end
    frame_valid = 1'b0;
    output_ready = 1'b1;
    #1;
    checks++;
    if (k != N || output_valid !== 1'b0) begin failures++; $display("[TB] FAIL xin_end: got words=%0d valid=%b expected words=12 valid=0", k, output_valid); end
    nextCycle();
  endtask

  // Reset after 5 words abandons the frame; a new frame restarts at word 0.
  task automatic test_reset_midframe();
    logic [W-1:0] expC;
    frame_data = mkSeq(14'd1, 14'd1);
    frame_valid = 1'b1;
    output_ready = 1'b1;
    nextCycle();
    frame_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (output_data !== 14'(i + 1)) begin failures++; $display("[TB] FAIL mid_pre_data[%0d]: got %h expected %h", i, output_data, 14'(i + 1)); end
      nextCycle();
    end
    reset = 1'b0;
    #1;
    checks++;
    if (output_valid !== 1'b0 || output_data !== 14'h0) begin failures++; $display("[TB] FAIL mid_reset_out: got %b/%h expected 0/0000", output_valid, output_data); end
    checks++;
    if (frame_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_frame_ready: got %b expected 0", frame_ready); end
`ifdef MATVEC3_FEEDER_LAST_EN
    checks++;
    if (output_last !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_last: got %b expected 0", output_last); end
`endif
    nextCycle();
    nextCycle();
    reset = 1'b1;
    #1;
    checks++;
    if (output_valid !== 1'b0 || frame_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_release: got valid=%b ready=%b expected valid=0 ready=1", output_valid, frame_ready); end
    nextCycle();
    #1;
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_no_resume: got %b expected 0", output_valid); end
    nextCycle();
    frame_data = mkSeq(14'h0100, 14'h0001);
    frame_valid = 1'b1;
    nextCycle();
    frame_valid = 1'b0;
    frame_data = 'x;
    for (int i = 0; i < N; i++) begin
      expC = 14'h0100 + 14'(i);
      #1;
      checks++;
      if (output_data !== expC || output_valid !== 1'b1) begin failures++; $display("[TB] FAIL mid_new_data[%0d]: got %h/%b expected %h/1", i, output_data, output_valid, expC); end
`ifdef MATVEC3_FEEDER_LAST_EN
      checks++;
      if (output_last !== (i == N - 1)) begin failures++; $display("[TB] FAIL mid_new_last[%0d]: got %b expected %b", i, output_last, (i == N - 1)); end
`endif
      nextCycle();
    end
    #1;
    checks++;
    if (output_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_new_end: got %b expected 0", output_valid); end
    nextCycle();
  endtask

  // Random frames with random output_ready against an in-order scoreboard.
  task automatic test_random_frames();
    logic [W-1:0]  q[$];
    logic [FW-1:0] cur;
    logic [W-1:0]  prevData;
    logic          prevStall;
    int            sent;
    int            cyc;
    sent = 0;
    cyc = 0;
    prevStall = 1'b0;
    prevData = '0;
    for (int e = 0; e < N; e++) cur[e*W +: W] = 14'($urandom);
    while ((sent < NUM_RANDOM_FRAMES || q.size() != 0 || output_valid === 1'b1) && cyc < RANDOM_CYCLE_LIMIT) begin
      frame_valid = (sent < NUM_RANDOM_FRAMES);
      frame_data = (sent < NUM_RANDOM_FRAMES) ? cur : 'x;
      output_ready = 1'($urandom % 2);
      #1;
      if (prevStall) begin
        checks++;
        if (output_valid !== 1'b1 || output_data !== prevData) begin failures++; $display("[TB] FAIL rand_stall_hold: got %b/%h expected 1/%h", output_valid, output_data, prevData); end
      end
      if (output_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("[TB] FAIL rand_extra_word: got %h expected no word", output_data);
        end else if (output_data !== q[0]) begin
          failures++;
          $display("[TB] FAIL rand_data: got %h expected %h", output_data, q[0]);
        end
        if (output_ready && q.size() != 0) void'(q.pop_front());
      end
      prevStall = (output_valid === 1'b1) && !output_ready;
      prevData = output_data;
      if (frame_valid && frame_ready === 1'b1) begin
        for (int e = 0; e < N; e++) q.push_back(cur[e*W +: W]);
        sent++;
        for (int e = 0; e < N; e++) cur[e*W +: W] = 14'($urandom);
      end
      cyc++;
      nextCycle();
    end
    frame_valid = 1'b0;
    output_ready = 1'b1;
    checks++;
    if (cyc >= RANDOM_CYCLE_LIMIT || sent != NUM_RANDOM_FRAMES || q.size() != 0) begin
      failures++;
      $display("[TB] FAIL rand_complete: got frames=%0d pending=%0d cycles=%0d expected frames=%0d pending=0", sent, q.size(), cyc, NUM_RANDOM_FRAMES);
    end
  endtask

  // Runs every scenario in sequence and prints the summary.
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_x_ignored();
    test_reset_midframe();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
